// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types and constants for the TMR fault manager and its error counters.
package cv32e40p_tmr_pkg;

    typedef enum logic [1:0] {
        HEALTHY  = 2'd0,
        DEGRADED = 2'd1,
        FAILED   = 2'd2
    } tmr_state_e;

    localparam logic [2:0] TMR_NONE = 3'b000;
    localparam logic [2:0] TMR_R1   = 3'b001;
    localparam logic [2:0] TMR_R2   = 3'b010;
    localparam logic [2:0] TMR_R3   = 3'b100;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/cv32e40p_tmr_err_counter.sv
// Per-replica saturating up/down error counter with leaky-decay input.
module cv32e40p_tmr_err_counter #(
    parameter int unsigned THR   = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_thr_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (inc_i && !dec_i && cnt_q != CNT_W'(THR)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (dec_i && !inc_i && cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    // Lookahead: the value this counter will hold after the edge sits at threshold.
    assign at_thr_o = (cnt_d == CNT_W'(THR));

endmodule

// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR fault manager: per-replica error accounting, broken-replica selection and fatal detection.
//   state    | meaning
//   HEALTHY  | full 3-way voting, errors counted with leaky decay
//   DEGRADED | one replica masked via broken_block_o, counters frozen
//   FAILED   | no reliable majority, fatal_o sticky until clear/reset
module cv32e40p_tmr_fault_manager
    import cv32e40p_tmr_pkg::*;
#(
    parameter int unsigned ERR_THRESHOLD = 4,
    parameter int unsigned WINDOW        = 64,
    localparam int unsigned CNT_W        = $clog2(ERR_THRESHOLD + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    input  logic               err_detected_1_i,
    input  logic               err_detected_2_i,
    input  logic               err_detected_3_i,
    input  logic               clear_i,
    output logic [2:0]         broken_block_o,
    output logic               fatal_o,
    output logic [1:0]         state_o,
    output logic [3*CNT_W-1:0] err_cnt_o
);

    localparam int unsigned WIN_W = $clog2(WINDOW);

    tmr_state_e       state_q, state_d;
    logic [2:0]       broken_q, broken_d;
    logic             fatal_q, fatal_d;
    logic [WIN_W-1:0] win_q, win_d;

    logic [2:0]       errs, inc, dec, at_thr, hit;
    logic [1:0]       nerr;
    logic             cnt_en, cnt_clr, wrap;

    assign errs = {err_detected_3_i, err_detected_2_i, err_detected_1_i};
    assign nerr = popcount3(errs);
    assign wrap = (win_q == WIN_W'(WINDOW - 1));
    assign hit  = inc & ~dec & at_thr;

    always_comb begin
        state_d  = state_q;
        broken_d = broken_q;
        fatal_d  = fatal_q;
        win_d    = win_q;
        inc      = 3'b000;
        dec      = 3'b000;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;
        if (clear_i) begin
            state_d  = HEALTHY;
            broken_d = TMR_NONE;
            fatal_d  = 1'b0;
            win_d    = '0;
            cnt_clr  = 1'b1;
        end else begin
            case (state_q)
                HEALTHY: begin
                    if (valid_i) begin
                        if (nerr >= 2'd2) begin
                            state_d = FAILED;
                            fatal_d = 1'b1;
                        end else begin
                            cnt_en = 1'b1;
                            win_d  = wrap ? '0 : win_q + WIN_W'(1);
                            inc    = errs;
                            dec    = {3{wrap}};
                            // nerr<=1 here, so hit is at most one-hot
                            if (hit != 3'b000) begin
                                state_d  = DEGRADED;
                                broken_d = hit;
                            end
                        end
                    end
                end
                DEGRADED: begin
                    if (valid_i && (errs & ~broken_q) != 3'b000) begin
                        state_d = FAILED;
                        fatal_d = 1'b1;
                    end
                end
                FAILED: begin
                    fatal_d = 1'b1;
                end
                default: begin
                    state_d = FAILED;
                    fatal_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= HEALTHY;
            broken_q <= TMR_NONE;
            fatal_q  <= 1'b0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            broken_q <= broken_d;
            fatal_q  <= fatal_d;
            win_q    <= win_d;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_cnt
        cv32e40p_tmr_err_counter #(
            .THR   (ERR_THRESHOLD),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (cnt_en),
            .inc_i    (inc[k]),
            .dec_i    (dec[k]),
            .clr_i    (cnt_clr),
            .cnt_o    (err_cnt_o[k*CNT_W +: CNT_W]),
            .at_thr_o (at_thr[k])
        );
    end

    assign broken_block_o = broken_q;
    assign fatal_o        = fatal_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Self-checking bench: directed vector table, corner-case sequences and a randomized run against a reference model.
module tb_cv32e40p_tmr_fault_manager;

    localparam int THR    = 4;
    localparam int WINDOW = 64;
    localparam int CNT_W  = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid_i;
    logic               err_detected_1_i;
    logic               err_detected_2_i;
    logic               err_detected_3_i;
    logic               clear_i;
    logic [2:0]         broken_block_o;
    logic               fatal_o;
    logic [1:0]         state_o;
    logic [3*CNT_W-1:0] err_cnt_o;

    always #5 clk = ~clk;

    cv32e40p_tmr_fault_manager dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_i          (valid_i),
        .err_detected_1_i (err_detected_1_i),
        .err_detected_2_i (err_detected_2_i),
        .err_detected_3_i (err_detected_3_i),
        .clear_i          (clear_i),
        .broken_block_o   (broken_block_o),
        .fatal_o          (fatal_o),
        .state_o          (state_o),
        .err_cnt_o        (err_cnt_o)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: counts, state as 0/1/2, broken replica index (-1 = none),
    // and the number of valid HEALTHY cycles since the last reset/clear.
    int m_cnt[3];
    int m_state;
    int m_broken;
    bit m_fatal;
    int m_valid_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        m_state      = 0;
        m_broken     = -1;
        m_fatal      = 1'b0;
        m_valid_seen = 0;
    endtask

    task automatic model_step(input logic r, input logic v, input logic c, input logic [2:0] e);
        int n;
        bit decay;
        n = int'(e[0]) + int'(e[1]) + int'(e[2]);
        if (!r || c) begin
            model_reset();
        end else if (m_state == 0 && v) begin
            if (n >= 2) begin
                m_state = 2;
                m_fatal = 1'b1;
            end else begin
                m_valid_seen++;
                decay = (m_valid_seen % WINDOW) == 0;
                for (int k = 0; k < 3; k++) begin
                    if (e[k] && !decay) begin
                        m_cnt[k]++;
                        if (m_cnt[k] == THR) begin
                            m_state  = 1;
                            m_broken = k;
                        end
                    end else if (!e[k] && decay && m_cnt[k] > 0) begin
                        m_cnt[k]--;
                    end
                end
            end
        end else if (m_state == 1 && v) begin
            for (int k = 0; k < 3; k++) begin
                if (e[k] && k != m_broken) begin
                    m_state = 2;
                    m_fatal = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [2:0] m_broken_vec();
        return (m_broken < 0) ? 3'b000 : 3'(1 << m_broken);
    endfunction

    function automatic logic [3*CNT_W-1:0] m_cnt_vec();
        logic [3*CNT_W-1:0] v;
        for (int k = 0; k < 3; k++) v[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
        return v;
    endfunction

    task automatic cycle(input logic r, input logic v, input logic c, input logic [2:0] e);
        rst_n            = r;
        valid_i          = v;
        clear_i          = c;
        err_detected_1_i = e[0];
        err_detected_2_i = e[1];
        err_detected_3_i = e[2];
        @(posedge clk);
        model_step(r, v, c, e);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " broken"}, 32'(broken_block_o), 32'(m_broken_vec()));
        chk({tag, " fatal"},  32'(fatal_o),        32'(m_fatal));
        chk({tag, " state"},  32'(state_o),        32'(m_state));
        chk({tag, " cnt"},    32'(err_cnt_o),      32'(m_cnt_vec()));
    endtask

    function automatic int cnt_of(input int k);
        return int'(err_cnt_o[k*CNT_W +: CNT_W]);
    endfunction

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic       clr;
        logic [2:0] err;      // {err3, err2, err1}
        logic [2:0] broken;
        logic       fatal;
        logic [1:0] state;
        int         c1;
        int         c2;
        int         c3;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 0, 0, 0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 2'd0, 0, 1, 0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 2'd0, 0, 2, 0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 2'd0, 0, 3, 0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b010, 3'b010, 1'b0, 2'd1, 0, 4, 0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b010, 3'b010, 1'b0, 2'd1, 0, 4, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b001, 3'b010, 1'b0, 2'd1, 0, 4, 0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b001, 3'b010, 1'b1, 2'd2, 0, 4, 0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b111, 3'b010, 1'b1, 2'd2, 0, 4, 0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 3'b100, 3'b000, 1'b0, 2'd0, 0, 0, 0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 3'b101, 3'b000, 1'b1, 2'd2, 0, 0, 0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 0, 0, 0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 3'b001, 3'b000, 1'b0, 2'd0, 1, 0, 0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 2'd0, 0, 0, 0};

        model_reset();
        #2;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].rst_n, vecs[i].valid, vecs[i].clr, vecs[i].err);
            chk($sformatf("vec%0d broken", i), 32'(broken_block_o), 32'(vecs[i].broken));
            chk($sformatf("vec%0d fatal", i),  32'(fatal_o),        32'(vecs[i].fatal));
            chk($sformatf("vec%0d state", i),  32'(state_o),        32'(vecs[i].state));
            chk($sformatf("vec%0d c1", i),     32'(cnt_of(0)),      32'(vecs[i].c1));
            chk($sformatf("vec%0d c2", i),     32'(cnt_of(1)),      32'(vecs[i].c2));
            chk($sformatf("vec%0d c3", i),     32'(cnt_of(2)),      32'(vecs[i].c3));
        end

        // Decay, and increment cancelled by a coincident wrap
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 3'b001);
        chk("decay pre", 32'(cnt_of(0)), 32'd3);
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 1'b0, 3'b000);
        chk("decay first wrap", 32'(cnt_of(0)), 32'd2);
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 1'b0, 3'b000);
        cycle(1'b1, 1'b1, 1'b0, 3'b001);
        chk("decay cancel", 32'(cnt_of(0)), 32'd2);
        chk("decay cancel state", 32'(state_o), 32'd0);
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 1'b0, 3'b000);
        chk("decay third wrap", 32'(cnt_of(0)), 32'd1);

        // DEGRADED on replica 1: its own flags ignored, others escalate
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 3'b001);
        chk("deg1 broken", 32'(broken_block_o), 32'h1);
        chk("deg1 state", 32'(state_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 3'b001);
            cycle(1'b1, 1'b1, 1'b0, 3'b000);
        end
        chk("deg1 pulses state", 32'(state_o), 32'd1);
        chk("deg1 pulses fatal", 32'(fatal_o), 32'd0);
        chk("deg1 pulses cnt", 32'(err_cnt_o), 32'(9'(4)));
        cycle(1'b1, 1'b1, 1'b0, 3'b110);
        chk("deg1 fail fatal", 32'(fatal_o), 32'd1);
        chk("deg1 fail state", 32'(state_o), 32'd2);
        chk("deg1 fail broken", 32'(broken_block_o), 32'h1);

        // Reset while DEGRADED
        cycle(1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 3'b100);
        chk("deg3 broken", 32'(broken_block_o), 32'h4);
        cycle(1'b0, 1'b1, 1'b0, 3'b111);
        chk("rst deg broken", 32'(broken_block_o), 32'h0);
        chk("rst deg state", 32'(state_o), 32'd0);
        chk("rst deg fatal", 32'(fatal_o), 32'd0);
        chk("rst deg cnt", 32'(err_cnt_o), 32'd0);

        // valid_i=0 freezes counters, window and state
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 3'b100);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b0, 3'b111);
        chk("novalid state", 32'(state_o), 32'd0);
        chk("novalid cnt3", 32'(cnt_of(2)), 32'd2);
        chk("novalid cnt12", 32'(cnt_of(0) + cnt_of(1)), 32'd0);
        for (int i = 0; i < 61; i++) cycle(1'b1, 1'b1, 1'b0, 3'b000);
        chk("novalid no early wrap", 32'(cnt_of(2)), 32'd2);
        cycle(1'b1, 1'b1, 1'b0, 3'b000);
        chk("novalid wrap", 32'(cnt_of(2)), 32'd1);

        // Randomized run against the reference model
        cycle(1'b0, 1'b0, 1'b0, 3'b000);
        check_model("rnd reset");
        for (int i = 0; i < 4000; i++) begin
            logic r, v, c;
            logic [2:0] e;
            int sel;
            r   = ($urandom_range(0, 499) != 0);
            c   = ($urandom_range(0, 79) == 0);
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 31);
            e   = 3'b000;
            if (sel < 4) e[$urandom_range(0, 2)] = 1'b1;
            else if (sel == 4) begin
                e = 3'b111;
                e[$urandom_range(0, 2)] = 1'b0;
            end else if (sel == 5) e = 3'b111;
            cycle(r, v, c, e);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
